// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states, byte-enable helper.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StResp
   } state_e;

   // Halves use addr_lo[1] only, so a misaligned half lands on its aligned-down lane pair.
   function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] addr_lo);
      logic [3:0] be;
      case (funct3)
         F3_B, F3_BU: be = 4'b0001 << addr_lo;
         F3_H, F3_HU: be = 4'b0011 << {addr_lo[1], 1'b0};
         F3_W:        be = 4'b1111;
         default:     be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Load extract/extend and store lane shift for the data-memory responder.
// DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of being aligned down.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rword,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic [31:0] wlane,
   output logic [3:0]  be,
   output logic        err
);

   logic        valid_f3;
   logic [1:0]  lane;
   logic [31:0] shifted;

   always_comb begin
      valid_f3 = 1'b0;
      lane     = addr_lo;
      case (funct3)
         F3_B:    valid_f3 = 1'b1;
         F3_BU:   valid_f3 = !we;
         F3_H:    begin valid_f3 = 1'b1; lane = {addr_lo[1], 1'b0}; end
         F3_HU:   begin valid_f3 = !we;  lane = {addr_lo[1], 1'b0}; end
         F3_W:    begin valid_f3 = 1'b1; lane = 2'b00; end
         default: valid_f3 = 1'b0;
      endcase

`ifdef DMEM_MISALIGN_TRAP_EN
      // Any bit dropped by the alignment above means the access was misaligned.
      err = !valid_f3 || (lane != addr_lo);
`else
      err = !valid_f3;
`endif

      shifted = rword >> {lane, 3'b000};
      wlane   = wdata << {lane, 3'b000};
      be      = (we && !err) ? byte_en(funct3, addr_lo) : 4'b0000;

      rdata = '0;
      if (!we && !err) begin
         case (funct3)
            F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   rdata = {24'b0, shifted[7:0]};
            F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   rdata = {16'b0, shifted[15:0]};
            F3_W:    rdata = shifted;
            default: rdata = '0;
         endcase
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, LATENCY wait cycles per access.
// DMEM_MISALIGN_TRAP_EN (in dmem_lane_align) selects trapping instead of aligning misaligned accesses.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH    = 256,
   parameter int unsigned LATENCY  = 1,
   parameter string       INIT_HEX = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned IdxW   = $clog2(DEPTH);
   localparam logic [3:0]  LatCnt = 4'(LATENCY);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              we_q;
   logic [2:0]        funct3_q;
   logic [IdxW+1:0]   addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;
   logic              err_q;

   logic [31:0]       mem [0:DEPTH-1];
   logic [IdxW-1:0]   idx;
   logic [31:0]       rword;
   logic [31:0]       align_rdata;
   logic [31:0]       wlane;
   logic [3:0]        be;
   logic              align_err;
   logic              accept;
   logic              commit;

   // Address bits above the index wrap by design.
   logic unused_addr;
   assign unused_addr = ^req_addr[31:IdxW+2];

   assign accept = (state_q == StIdle) && req_valid;
   assign commit = (state_q == StAccess) && (cnt_q == LatCnt);
   assign idx    = addr_q[IdxW+1:2];
   assign rword  = mem[idx];

   dmem_lane_align u_align (
      .we      (we_q),
      .funct3  (funct3_q),
      .addr_lo (addr_q[1:0]),
      .rword   (rword),
      .wdata   (wdata_q),
      .rdata   (align_rdata),
      .wlane   (wlane),
      .be      (be),
      .err     (align_err)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) state_d = StAccess;
         end
         StAccess: begin
            if (cnt_q == LatCnt) begin
               state_d = StResp;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StResp: begin
            if (resp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         we_q     <= 1'b0;
         funct3_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr[IdxW+1:0];
            wdata_q  <= req_wdata;
         end
         if (commit) begin
            rdata_q <= align_rdata;
            err_q   <= align_err;
         end
      end
   end

   // Array has no reset; a reset in the commit cycle suppresses the write.
   always_ff @(posedge clk) begin
      if (!rst && commit && we_q) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
         end
      end
   end

   assign req_ready  = (state_q == StIdle);
   assign resp_valid = (state_q == StResp);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed table, multi-cycle corner cases, random vs. model.
module tb_dmem_responder;

   localparam int unsigned LAT   = 2;
   localparam int unsigned DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   dmem_responder #(
      .DEPTH    (DEPTH),
      .LATENCY  (LAT),
      .INIT_HEX ("")
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [31:0] model [DEPTH];

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        er;
   } vec_t;

   vec_t tbl [19];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Reference: byte-granular memory, sizes and extension from funct3 arithmetic.
   task automatic ref_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er);
      int unsigned n, off, idx;
      logic [31:0] base, val;
      bit ok;
      n  = 32'd1 << f3[1:0];
      ok = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      er = !ok;
`ifdef DMEM_MISALIGN_TRAP_EN
      if (ok && (a % n) != 0) er = 1'b1;
`endif
      rd = '0;
      if (er) return;
      base = a - (a % n);
      idx  = (base / 4) % DEPTH;
      off  = base % 4;
      val  = '0;
      for (int i = 0; i < int'(n); i++) begin
         if (we) model[idx][8*(off+i) +: 8] = wd[8*i +: 8];
         else    val = val | (32'(model[idx][8*(off+i) +: 8]) << (8*i));
      end
      if (!we) begin
         if (n < 4 && !f3[2] && val[8*n-1]) val = val | ~((32'd1 << (8*n)) - 32'd1);
         rd = val;
      end
   endtask

   task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
      int n = 0;
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: req_ready=%0b expected 1", req_ready);
      end
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
   endtask

   task automatic wait_resp(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!resp_valid && lat < 100);
      chk("latency", 32'(lat), 32'(LAT + 2));
   endtask

   task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
      int lat;
      send(we, f3, a, wd);
      wait_resp(lat);
      rd = resp_rdata;
      er = resp_err;
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      @(negedge clk);
      chk("ready_after_resp", 32'(req_ready), 32'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd, erd;
      logic        er, ere;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a, wd;
      int          lat;

      tbl[0]  = '{1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
      tbl[1]  = '{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
      tbl[2]  = '{1'b1, 3'b000, 32'h11,  32'h1234565A, 32'h0,        1'b0};
      tbl[3]  = '{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEAD5AEF, 1'b0};
      tbl[4]  = '{1'b0, 3'b000, 32'h13,  32'h0,        32'hFFFFFFDE, 1'b0};
      tbl[5]  = '{1'b0, 3'b100, 32'h13,  32'h0,        32'h000000DE, 1'b0};
      tbl[6]  = '{1'b0, 3'b001, 32'h12,  32'h0,        32'hFFFFDEAD, 1'b0};
      tbl[7]  = '{1'b0, 3'b101, 32'h12,  32'h0,        32'h0000DEAD, 1'b0};
      tbl[8]  = '{1'b1, 3'b001, 32'h12,  32'hABCD1234, 32'h0,        1'b0};
      tbl[9]  = '{1'b0, 3'b010, 32'h10,  32'h0,        32'h12345AEF, 1'b0};
`ifdef DMEM_MISALIGN_TRAP_EN
      tbl[10] = '{1'b0, 3'b010, 32'h11,  32'h0,        32'h0,        1'b1};
`else
      tbl[10] = '{1'b0, 3'b010, 32'h11,  32'h0,        32'h12345AEF, 1'b0};
`endif
      tbl[11] = '{1'b0, 3'b111, 32'h10,  32'h0,        32'h0,        1'b1};
      tbl[12] = '{1'b1, 3'b011, 32'h10,  32'hFFFFFFFF, 32'h0,        1'b1};
      tbl[13] = '{1'b1, 3'b010, 32'h410, 32'h55667788, 32'h0,        1'b0};
      tbl[14] = '{1'b0, 3'b010, 32'h10,  32'h0,        32'h55667788, 1'b0};
`ifdef DMEM_MISALIGN_TRAP_EN
      tbl[15] = '{1'b0, 3'b001, 32'h13,  32'h0,        32'h0,        1'b1};
`else
      tbl[15] = '{1'b0, 3'b001, 32'h13,  32'h0,        32'h00005566, 1'b0};
`endif
      tbl[16] = '{1'b1, 3'b100, 32'h10,  32'hFFFFFFFF, 32'h0,        1'b1};
      tbl[17] = '{1'b0, 3'b010, 32'h10,  32'h0,        32'h55667788, 1'b0};
      tbl[18] = '{1'b0, 3'b000, 32'h10,  32'h0,        32'hFFFFFF88, 1'b0};

      for (int i = 0; i < DEPTH; i++) model[i] = '0;

      rst        = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = '0;
      req_addr   = '0;
      req_wdata  = '0;
      resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_req_ready",  32'(req_ready),  32'd1);
      chk("reset_resp_valid", 32'(resp_valid), 32'd0);
      chk("reset_resp_rdata", resp_rdata,      32'd0);
      chk("reset_resp_err",   32'(resp_err),   32'd0);

      for (int i = 0; i < 19; i++) begin
         ref_op(tbl[i].we, tbl[i].f3, tbl[i].a, tbl[i].wd, erd, ere);
         xact(tbl[i].we, tbl[i].f3, tbl[i].a, tbl[i].wd, rd, er);
         chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
         chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].er));
      end

      // Response held off: outputs stay put and a competing request is ignored.
      send(1'b0, 3'b010, 32'h10, 32'h0);
      wait_resp(lat);
      for (int i = 0; i < 5; i++) begin
         req_valid  = 1'b1;
         req_we     = 1'b1;
         req_funct3 = 3'b010;
         req_addr   = 32'h10;
         req_wdata  = 32'h0;
         chk("hold_resp_valid", 32'(resp_valid), 32'd1);
         chk("hold_resp_rdata", resp_rdata,      32'h55667788);
         chk("hold_req_ready",  32'(req_ready),  32'd0);
         @(negedge clk);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      @(negedge clk);
      chk("hold_ready_after", 32'(req_ready), 32'd1);
      xact(1'b0, 3'b010, 32'h10, 32'h0, rd, er);
      chk("hold_no_write", rd, 32'h55667788);

      // Reset during the commit cycle of a store aborts it.
      ref_op(1'b1, 3'b010, 32'h20, 32'h11223344, erd, ere);
      xact(1'b1, 3'b010, 32'h20, 32'h11223344, rd, er);
      xact(1'b0, 3'b010, 32'h20, 32'h0, rd, er);
      chk("abort_pre_load", rd, 32'h11223344);
      send(1'b1, 3'b010, 32'h20, 32'hFFFFFFFF);
      repeat (LAT) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_req_ready",  32'(req_ready),  32'd1);
      chk("abort_resp_valid", 32'(resp_valid), 32'd0);
      chk("abort_resp_rdata", resp_rdata,      32'd0);
      xact(1'b0, 3'b010, 32'h20, 32'h0, rd, er);
      chk("abort_old_value", rd, 32'h11223344);

      // Give the random region known contents before reading it back.
      for (int w = 0; w < 16; w++) begin
         wd = $urandom;
         ref_op(1'b1, 3'b010, 32'(w * 4), wd, erd, ere);
         xact(1'b1, 3'b010, 32'(w * 4), wd, rd, er);
      end

      for (int i = 0; i < 80; i++) begin
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = 32'($urandom_range(0, 63)) | (32'($urandom_range(0, 15)) << 10);
         wd = $urandom;
         ref_op(we, f3, a, wd, erd, ere);
         xact(we, f3, a, wd, rd, er);
         chk($sformatf("rnd%0d_rdata we=%0b f3=%0d a=%h", i, we, f3, a), rd, erd);
         chk($sformatf("rnd%0d_err we=%0b f3=%0d a=%h", i, we, f3, a), 32'(er), 32'(ere));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
